ball_controller: RTL and testbench

- Per-frame sequencer for the pong ball.
- Holds ball position and direction, and advances the ball once per frame on the vertical-sync assertion edge.
- Resolves wall bounces, paddle hits and misses, and runs the serve/play/miss game state machine.
- Sits between vga (frame timing), paddle (paddle_x/paddle_y) and the renderer, which consumes ball_x/ball_y as the ball centre.

---
 rtl/ball_controller.sv | 192 +++++++++++++++++++
 tb/tb_ball_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ball_controller.sv
// Pong ball sequencer: frame-stepped position, bounces, paddle hits and the serve/play/miss FSM.
// Optional macro BALL_SPEEDUP_EN: each paddle hit raises horizontal speed up to MAX_SPEED_X.
module ball_controller #(
    parameter int POSITION_WIDTH = 11,
    parameter int X_MIN          = 50,
    parameter int X_MAX          = 1230,
    parameter int Y_MIN          = 50,
    parameter int Y_MAX          = 750,
    parameter int RADIUS         = 10,
    parameter int SPEED_X        = 4,
    parameter int SPEED_Y        = 3,
    parameter int START_X        = 640,
    parameter int START_Y        = 400,
    parameter int PADDLE_WIDTH   = 20,
    parameter int PADDLE_LENGTH  = 200,
    parameter int MISS_FRAMES    = 60,
    parameter int MAX_SPEED_X    = 12
) (
    input  logic                      pixel_clock,
    input  logic                      reset_n,
    input  logic                      vertical_sync,
    input  logic                      serve,
    input  logic [POSITION_WIDTH-1:0] paddle_x,
    input  logic [POSITION_WIDTH-1:0] paddle_y,
    output logic [POSITION_WIDTH-1:0] ball_x,
    output logic [POSITION_WIDTH-1:0] ball_y,
    output logic [1:0]                state,
    output logic [7:0]                rally_count,
    output logic                      hit,
    output logic                      miss
);
    localparam int W  = POSITION_WIDTH;
    localparam int E  = POSITION_WIDTH + 1;
    localparam int TW = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

    localparam logic [W-1:0]  SX0    = W'(START_X);
    localparam logic [W-1:0]  SY0    = W'(START_Y);
    localparam logic [W-1:0]  SPD_Y  = W'(SPEED_Y);
    localparam logic [W-1:0]  Y_TOP  = W'(Y_MIN + RADIUS);
    localparam logic [W-1:0]  Y_BOT  = W'(Y_MAX - RADIUS);
    localparam logic [W-1:0]  X_RGT  = W'(X_MAX - RADIUS);
    localparam logic [E-1:0]  UP_LIM = E'(Y_MIN + RADIUS + SPEED_Y);
    localparam logic [E-1:0]  DN_ADD = E'(RADIUS + SPEED_Y);
    localparam logic [E-1:0]  Y_MAXE = E'(Y_MAX);
    localparam logic [E-1:0]  X_MAXE = E'(X_MAX);
    localparam logic [E-1:0]  RAD_E  = E'(RADIUS);
    localparam logic [E-1:0]  XL_LIM = E'(X_MIN + RADIUS);
    localparam logic [E-1:0]  PW_E   = E'(PADDLE_WIDTH);
    localparam logic [E-1:0]  PL_E   = E'(PADDLE_LENGTH);
    localparam logic [TW-1:0] T_LAST = TW'(MISS_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        MISS = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t        st;
    logic          vs_q;
    logic          dir_x;
    logic          dir_y;
    logic          serve_toggle;
    logic [TW-1:0] timer;
    logic [W-1:0]  speed_x;

`ifdef BALL_SPEEDUP_EN
    localparam logic [W-1:0] SPD_MAX = W'(MAX_SPEED_X);
    logic [W-1:0] speed_q;
    assign speed_x = speed_q;
`else
    assign speed_x = W'(SPEED_X);
`endif

    logic         tick;
    logic [E-1:0] bx_e, by_e, py_e, sx_e, face_r;
    logic         up_wall, dn_wall, r_wall, in_x, in_y;
    logic         hit_now, miss_now;

    // All boundary tests use one extra bit and additive forms only.
    always_comb begin
        tick     = vertical_sync & ~vs_q;
        bx_e     = {1'b0, ball_x};
        by_e     = {1'b0, ball_y};
        py_e     = {1'b0, paddle_y};
        sx_e     = {1'b0, speed_x};
        face_r   = {1'b0, paddle_x} + PW_E + RAD_E;
        up_wall  = by_e < UP_LIM;
        dn_wall  = (by_e + DN_ADD) > Y_MAXE;
        r_wall   = (bx_e + RAD_E + sx_e) > X_MAXE;
        in_x     = (bx_e >= face_r) && (bx_e < face_r + sx_e);
        in_y     = (by_e >= py_e) && (by_e <= py_e + PL_E);
        hit_now  = ~dir_x & in_x & in_y;
        miss_now = ~dir_x & ~hit_now & (bx_e < XL_LIM + sx_e);
    end

    assign state = st;

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            st           <= IDLE;
            vs_q         <= 1'b0;
            ball_x       <= SX0;
            ball_y       <= SY0;
            dir_x        <= 1'b1;
            dir_y        <= 1'b0;
            serve_toggle <= 1'b0;
            timer        <= '0;
            rally_count  <= 8'd0;
            hit          <= 1'b0;
            miss         <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed_q      <= W'(SPEED_X);
`endif
        end else begin
            vs_q <= vertical_sync;
            hit  <= 1'b0;
            miss <= 1'b0;
            if (tick) begin
                unique case (st)
                    IDLE: begin
                        ball_x <= SX0;
                        ball_y <= SY0;
                        if (serve) begin
                            st           <= PLAY;
                            dir_x        <= 1'b1;
                            dir_y        <= serve_toggle;
                            serve_toggle <= ~serve_toggle;
                            rally_count  <= 8'd0;
`ifdef BALL_SPEEDUP_EN
                            speed_q      <= W'(SPEED_X);
`endif
                        end
                    end
                    PLAY: begin
                        if (hit_now) begin
                            ball_x <= face_r[W-1:0];
                            dir_x  <= 1'b1;
                            hit    <= 1'b1;
                            if (rally_count != 8'hFF)
                                rally_count <= rally_count + 8'd1;
`ifdef BALL_SPEEDUP_EN
                            if (speed_q < SPD_MAX)
                                speed_q <= speed_q + 1'b1;
`endif
                        end else if (miss_now) begin
                            st    <= MISS;
                            miss  <= 1'b1;
                            timer <= '0;
                        end else if (dir_x && r_wall) begin
                            ball_x <= X_RGT;
                            dir_x  <= 1'b0;
                        end else if (dir_x) begin
                            ball_x <= ball_x + speed_x;
                        end else begin
                            ball_x <= ball_x - speed_x;
                        end
                        // A miss freezes the ball on both axes.
                        if (!miss_now) begin
                            if (!dir_y && up_wall) begin
                                ball_y <= Y_TOP;
                                dir_y  <= 1'b1;
                            end else if (dir_y && dn_wall) begin
                                ball_y <= Y_BOT;
                                dir_y  <= 1'b0;
                            end else if (dir_y) begin
                                ball_y <= ball_y + SPD_Y;
                            end else begin
                                ball_y <= ball_y - SPD_Y;
                            end
                        end
                    end
                    MISS: begin
                        if (timer == T_LAST) begin
                            st     <= IDLE;
                            ball_x <= SX0;
                            ball_y <= SY0;
                            timer  <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    BAD: begin
                        st     <= IDLE;
                        ball_x <= SX0;
                        ball_y <= SY0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller: reset, serve, wall bounces, paddle hit, miss timeout.
module tb_ball_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b0;
    logic        serve = 1'b0;
    logic [10:0] paddle_x = 11'd60;
    logic [10:0] paddle_y = 11'd300;

    logic [10:0] m_x, m_y, w_x, w_y, p_x, p_y;
    logic [1:0]  m_st, w_st, p_st;
    logic [7:0]  m_rc, w_rc, p_rc;
    logic        m_hit, w_hit, p_hit, m_miss, w_miss, p_miss;

    int total = 0;
    int passed = 0;

`ifdef BALL_SPEEDUP_EN
    localparam int X_T5    = 95;
    localparam int MISS_T  = 16;
    localparam int FROZEN_Y = 355;
`else
    localparam int X_T5    = 94;
    localparam int MISS_T  = 18;
    localparam int FROZEN_Y = 349;
`endif

    always #5 clk = ~clk;

    ball_controller u_main (
        .pixel_clock(clk), .reset_n(rst_n), .vertical_sync(vs),
        .serve(serve), .paddle_x(paddle_x), .paddle_y(paddle_y),
        .ball_x(m_x), .ball_y(m_y), .state(m_st),
        .rally_count(m_rc), .hit(m_hit), .miss(m_miss)
    );

    ball_controller #(.START_X(1218), .START_Y(62)) u_wall (
        .pixel_clock(clk), .reset_n(rst_n), .vertical_sync(vs),
        .serve(serve), .paddle_x(paddle_x), .paddle_y(paddle_y),
        .ball_x(w_x), .ball_y(w_y), .state(w_st),
        .rally_count(w_rc), .hit(w_hit), .miss(w_miss)
    );

    ball_controller #(.X_MAX(110), .START_X(100)) u_pad (
        .pixel_clock(clk), .reset_n(rst_n), .vertical_sync(vs),
        .serve(serve), .paddle_x(paddle_x), .paddle_y(paddle_y),
        .ball_x(p_x), .ball_y(p_y), .state(p_st),
        .rally_count(p_rc), .hit(p_hit), .miss(p_miss)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic frame();
        @(negedge clk) vs = 1'b0;
        @(negedge clk) vs = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", m_x, 640);
        chk("rst_y", m_y, 400);
        chk("rst_state", m_st, 0);
        chk("rst_rally", m_rc, 0);
        chk("rst_hit", m_hit, 0);
        chk("rst_miss", m_miss, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        serve = 1'b1;
        frame();
        serve = 1'b0;
        chk("serve_state", m_st, 1);
        chk("serve_x", m_x, 640);
        chk("serve_y", m_y, 400);

        frame();
        chk("t1_main_x", m_x, 644);
        chk("t1_main_y", m_y, 397);
        chk("t1_wall_x", w_x, 1220);
        chk("t1_wall_y", w_y, 60);
        chk("t1_pad_x", p_x, 100);

        frame();
        chk("t2_wall_x", w_x, 1216);
        chk("t2_wall_y", w_y, 63);
        chk("t2_pad_x", p_x, 96);

        frame();
        chk("t3_pad_x", p_x, 92);
        chk("t3_hit", p_hit, 0);

        frame();
        chk("t4_pad_x", p_x, 90);
        chk("t4_hit", p_hit, 1);
        chk("t4_rally", p_rc, 1);
        @(posedge clk);
        #1;
        chk("t4_hit_clear", p_hit, 0);
        paddle_y = 11'd600;

        frame();
        chk("t5_pad_x", p_x, X_T5);
        chk("t5_pad_y", p_y, 385);

        for (int t = 6; t < MISS_T; t++) frame();
        chk("pre_miss_state", p_st, 1);
        frame();
        chk("miss_state", p_st, 2);
        chk("miss_pulse", p_miss, 1);
        chk("miss_x", p_x, 60);
        chk("miss_y", p_y, FROZEN_Y);
        @(posedge clk);
        #1;
        chk("miss_clear", p_miss, 0);

        serve = 1'b1;
        for (int t = 0; t < 59; t++) frame();
        chk("hold_state", p_st, 2);
        chk("hold_x", p_x, 60);
        chk("hold_y", p_y, FROZEN_Y);
        frame();
        chk("timeout_state", p_st, 0);
        chk("timeout_x", p_x, 100);
        chk("timeout_y", p_y, 400);

        frame();
        serve = 1'b0;
        chk("reserve_state", p_st, 1);
        chk("reserve_y", p_y, 400);
        chk("reserve_rally", p_rc, 0);
        frame();
        chk("reserve_down_y", p_y, 403);
        chk("reserve_x", p_x, 100);

        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_state", p_st, 0);
        chk("async_rst_main_x", m_x, 640);
        chk("async_rst_main_st", m_st, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
